// File: rtl/serial_link_scheduler_pkg.sv
// Shared types and constants for the serial link scheduler.
// Optional feature macro: SERIAL_PARITY_EN (adds an even-parity bit before STOP).
package serial_link_pkg;

    localparam int   NREQ_DEF   = 4;
    localparam int   LEN_W_DEF  = 4;
    localparam int   DATA_W_DEF = 15;
    localparam logic IDLE_LVL   = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_ID,
        S_LEN,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/serial_link_scheduler_if.sv
// Requester-side bus of the scheduler: requests, payloads, grants and serial line.
interface serial_link_scheduler_if #(
    parameter int NREQ   = 4,
    parameter int LEN_W  = 4,
    parameter int DATA_W = 15
) ();
    logic [NREQ-1:0]              req;
    logic [NREQ-1:0][LEN_W-1:0]   len_bus;
    logic [NREQ-1:0][DATA_W-1:0]  data_bus;
    logic [NREQ-1:0]              gnt;
    logic                         busy;
    logic                         done;
    logic                         serout;

    modport master (output req, len_bus, data_bus, input gnt, busy, done, serout);
    modport slave  (input req, len_bus, data_bus, output gnt, busy, done, serout);
endinterface

// File: rtl/serial_link_scheduler_rr_arbiter.sv
// Round-robin arbiter: first active request at or after ptr wins (one-hot).
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int ID_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] ptr,
    output logic [NREQ-1:0] grant
);
    logic [ID_W-1:0] idx;
    logic            found;

    // Scan requesters starting at ptr, wrapping modulo NREQ.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = ID_W'((int'(ptr) + k) % NREQ);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end
endmodule

// File: rtl/serial_link_scheduler.sv
// Round-robin scheduler serialising granted requests onto one line:
// start(0), ID (MSB first), LEN (MSB first), L data bits (MSB first), stop(1).
// SERIAL_PARITY_EN inserts an even-parity bit over ID/LEN/data before STOP.
module serial_link_scheduler
    import serial_link_pkg::*;
#(
    parameter int NREQ   = NREQ_DEF,
    parameter int LEN_W  = LEN_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input logic               clk,
    input logic               rst,
    serial_link_scheduler_if.slave bus
);
    localparam int ID_W  = $clog2(NREQ);
    localparam int CNT_W = max_int(ID_W, LEN_W);

    state_e            state;
    logic [CNT_W-1:0]  cnt;
    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   id_sr;
    logic [LEN_W-1:0]  len_sr;
    logic [LEN_W-1:0]  len_q;
    logic [DATA_W-1:0] data_sr;
    logic [NREQ-1:0]   grant;
    logic [ID_W-1:0]   win;
    logic [DATA_W-1:0] win_data;
`ifdef SERIAL_PARITY_EN
    logic              par;
`endif

    rr_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) u_arb (
        .req   (bus.req),
        .ptr   (ptr),
        .grant (grant)
    );

    // One-hot grant to winner index.
    always_comb begin
        win = '0;
        for (int i = 0; i < NREQ; i++)
            if (grant[i]) win = ID_W'(i);
    end

    // Left-align the L payload bits so DATA just shifts out the MSB; unsent bits fall off.
    assign win_data = bus.data_bus[win] << (DATA_W - int'(bus.len_bus[win]));

    // Frame FSM; serout is registered and loaded with the bit of the state being entered.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            ptr        <= '0;
            id_sr      <= '0;
            len_sr     <= '0;
            len_q      <= '0;
            data_sr    <= '0;
            bus.gnt    <= '0;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b0;
            bus.serout <= IDLE_LVL;
`ifdef SERIAL_PARITY_EN
            par        <= 1'b0;
`endif
        end else begin
            bus.gnt  <= '0;
            bus.done <= 1'b0;
            case (state)
                S_IDLE: begin
                    bus.serout <= IDLE_LVL;
                    if (|bus.req) begin
                        bus.gnt    <= grant;
                        ptr        <= (win == ID_W'(NREQ - 1)) ? '0 : win + 1'b1;
                        id_sr      <= win;
                        len_sr     <= bus.len_bus[win];
                        len_q      <= bus.len_bus[win];
                        data_sr    <= win_data;
`ifdef SERIAL_PARITY_EN
                        par        <= ^{win, bus.len_bus[win], win_data};
`endif
                        cnt        <= '0;
                        bus.busy   <= 1'b1;
                        bus.serout <= 1'b0;
                        state      <= S_START;
                    end
                end
                S_START: begin
                    bus.serout <= id_sr[ID_W-1];
                    id_sr      <= id_sr << 1;
                    cnt        <= CNT_W'(ID_W - 1);
                    state      <= S_ID;
                end
                S_ID: begin
                    if (cnt != '0) begin
                        bus.serout <= id_sr[ID_W-1];
                        id_sr      <= id_sr << 1;
                        cnt        <= cnt - 1'b1;
                    end else begin
                        bus.serout <= len_sr[LEN_W-1];
                        len_sr     <= len_sr << 1;
                        cnt        <= CNT_W'(LEN_W - 1);
                        state      <= S_LEN;
                    end
                end
                S_LEN: begin
                    if (cnt != '0) begin
                        bus.serout <= len_sr[LEN_W-1];
                        len_sr     <= len_sr << 1;
                        cnt        <= cnt - 1'b1;
                    end else if (len_q != '0) begin
                        bus.serout <= data_sr[DATA_W-1];
                        data_sr    <= data_sr << 1;
                        cnt        <= CNT_W'(len_q - 1'b1);
                        state      <= S_DATA;
                    end else begin
                        cnt <= '0;
`ifdef SERIAL_PARITY_EN
                        bus.serout <= par;
                        state      <= S_PARITY;
`else
                        bus.serout <= 1'b1;
                        state      <= S_STOP;
`endif
                    end
                end
                S_DATA: begin
                    if (cnt != '0) begin
                        bus.serout <= data_sr[DATA_W-1];
                        data_sr    <= data_sr << 1;
                        cnt        <= cnt - 1'b1;
                    end else begin
`ifdef SERIAL_PARITY_EN
                        bus.serout <= par;
                        state      <= S_PARITY;
`else
                        bus.serout <= 1'b1;
                        state      <= S_STOP;
`endif
                    end
                end
                S_PARITY: begin
                    bus.serout <= 1'b1;
                    cnt        <= '0;
                    state      <= S_STOP;
                end
                S_STOP: begin
                    bus.serout <= IDLE_LVL;
                    bus.busy   <= 1'b0;
                    bus.done   <= 1'b1;
                    cnt        <= '0;
                    state      <= S_IDLE;
                end
                default: begin
                    bus.serout <= IDLE_LVL;
                    bus.busy   <= 1'b0;
                    state      <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_link_scheduler.sv
// Bench for serial_link_scheduler: directed scenarios then random traffic, every
// cycle compared against a bit-queue reference of the frame format.
module tb_serial_link_scheduler;
    localparam int NREQ = 4, LEN_W = 4, DATA_W = 15, ID_W = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    serial_link_scheduler_if #(.NREQ(NREQ), .LEN_W(LEN_W), .DATA_W(DATA_W)) bus ();
    serial_link_scheduler #(.NREQ(NREQ), .LEN_W(LEN_W), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference: expected remaining line bits of the frame in progress.
    bit        q[$];
    bit        in_frame = 1'b0;
    int        mptr     = 0;
    logic       e_serout, e_busy, e_done;
    logic [3:0] e_gnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void build_frame(input int id, input int len, input logic [DATA_W-1:0] d);
        bit p = 1'b0;
        bit b;
        q.push_back(1'b0);
        for (int k = ID_W - 1; k >= 0; k--) begin b = bit'((id >> k) & 1); p ^= b; q.push_back(b); end
        for (int k = LEN_W - 1; k >= 0; k--) begin b = bit'((len >> k) & 1); p ^= b; q.push_back(b); end
        for (int k = len - 1; k >= 0; k--) begin b = d[k]; p ^= b; q.push_back(b); end
`ifdef SERIAL_PARITY_EN
        q.push_back(p);
`endif
        q.push_back(1'b1);
    endfunction

    // Advance the reference by one clock edge using the inputs currently driven.
    function automatic void model_edge();
        int w;
        e_gnt  = '0;
        e_done = 1'b0;
        if (!rst) begin
            q.delete(); in_frame = 1'b0; mptr = 0;
            e_serout = 1'b1; e_busy = 1'b0;
            return;
        end
        if (q.size() > 0) begin
            e_serout = q.pop_front(); e_busy = 1'b1;
        end else if (in_frame) begin
            in_frame = 1'b0; e_done = 1'b1; e_serout = 1'b1; e_busy = 1'b0;
        end else begin
            e_serout = 1'b1; e_busy = 1'b0; w = -1;
            for (int k = 0; k < NREQ; k++)
                if (w < 0 && bus.req[(mptr + k) % NREQ]) w = (mptr + k) % NREQ;
            if (w >= 0) begin
                build_frame(w, int'(bus.len_bus[w]), bus.data_bus[w]);
                e_gnt[w] = 1'b1;
                e_serout = q.pop_front(); e_busy = 1'b1; in_frame = 1'b1;
                mptr = (w + 1) % NREQ;
            end
        end
    endfunction

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        chk("serout", 32'(bus.serout), 32'(e_serout));
        chk("gnt",    32'(bus.gnt),    32'(e_gnt));
        chk("busy",   32'(bus.busy),   32'(e_busy));
        chk("done",   32'(bus.done),   32'(e_done));
    endtask

`ifdef SERIAL_PARITY_EN
    localparam int FL2 = 14;
    localparam logic [31:0] FRAME2 = 32'b0_10_0101_10110_0_1;
    localparam int FL4 = 9;
    localparam logic [31:0] FRAME4 = 32'b0_01_0000_1_1;
`else
    localparam int FL2 = 13;
    localparam logic [31:0] FRAME2 = 32'b0_10_0101_10110_1;
    localparam int FL4 = 8;
    localparam logic [31:0] FRAME4 = 32'b0_01_0000_1;
`endif

    initial begin
        logic [31:0] sv;
        int order[$];
        int exp_ord[4];
        exp_ord = '{0, 1, 3, 0};

        rst = 1'b0;
        bus.req = '0; bus.len_bus = '0; bus.data_bus = '0;

        // Reset held with all requests pending: line stays idle.
        bus.req = 4'b1111;
        step(); step();
        chk("rst_serout", 32'(bus.serout), 32'd1);
        chk("rst_gnt",    32'(bus.gnt),    32'd0);
        rst = 1'b1; bus.req = '0;
        step();

        // Single frame from requester 2, L=5.
        bus.len_bus[2] = 4'd5; bus.data_bus[2] = 15'b10110; bus.req = 4'b0100;
        step();
        chk("f2_gnt", 32'(bus.gnt), 32'b0100);
        bus.req = '0;
        bus.data_bus[2] = 15'h7fff;
        sv = 32'(bus.serout);
        for (int k = 1; k < FL2; k++) begin step(); sv = (sv << 1) | 32'(bus.serout); end
        chk("f2_frame", sv, FRAME2);
        step();
        chk("f2_done", 32'(bus.done), 32'd1);
        step();

        // Round robin with 1011 held; pointer reset first.
        rst = 1'b0; step(); rst = 1'b1;
        for (int i = 0; i < NREQ; i++) begin bus.len_bus[i] = 4'd2; bus.data_bus[i] = 15'($urandom); end
        bus.req = 4'b1011;
        for (int c = 0; c < 200 && order.size() < 4; c++) begin
            step();
            for (int i = 0; i < NREQ; i++) if (bus.gnt[i]) order.push_back(i);
        end
        bus.req = '0;
        chk("rr_count", 32'(order.size()), 32'd4);
        for (int k = 0; k < 4; k++) if (k < order.size()) chk("rr_order", 32'(order[k]), 32'(exp_ord[k]));
        for (int c = 0; c < 20; c++) step();

        // Zero-length payload from requester 1.
        bus.len_bus[1] = 4'd0; bus.req = 4'b0010;
        step();
        bus.req = '0;
        sv = 32'(bus.serout);
        for (int k = 1; k < FL4; k++) begin step(); sv = (sv << 1) | 32'(bus.serout); end
        chk("f4_frame", sv, FRAME4);
        step();
        chk("f4_done", 32'(bus.done), 32'd1);
        step(); step();

        // Reset in the middle of an L=15 frame.
        bus.len_bus[3] = 4'd15; bus.data_bus[3] = 15'h5a5a; bus.req = 4'b1000;
        step();
        bus.req = '0;
        for (int c = 0; c < 10; c++) step();
        rst = 1'b0;
        step();
        chk("abort_serout", 32'(bus.serout), 32'd1);
        rst = 1'b1; bus.req = 4'b1001;
        step();
        chk("abort_prio", 32'(bus.gnt), 32'b0001);
        bus.req = '0;
        for (int c = 0; c < 25; c++) step();

        // Random traffic with occasional withdrawals and resets.
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (e_gnt[i] && $urandom_range(1, 0) == 1) begin
                    bus.req[i] = 1'b0;
                end else if (!bus.req[i] && $urandom_range(3, 0) == 0) begin
                    bus.req[i] = 1'b1;
                    bus.len_bus[i] = 4'($urandom_range(15, 0));
                    bus.data_bus[i] = 15'($urandom);
                end else if (bus.req[i] && $urandom_range(63, 0) == 0) begin
                    bus.req[i] = 1'b0;
                end
            end
            rst = ($urandom_range(299, 0) == 0) ? 1'b0 : 1'b1;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
